fetch_pc_ctrl: RTL and testbench

//  Fetch-side consumer of the branch decision (b_out): owns the PC, issues instruction-memory

---
 rtl/rv32_pkg.sv | 24 ++
 rtl/fetch_pc_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: fetch FSM states, the canonical NOP encoding and
// the branch-type enum also used by the EX-stage branch logic.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    B_NONE,
    B_EQ,
    B_NE,
    B_LT,
    B_GE,
    B_LTU,
    B_GEU
  } b_t;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the PC, runs the imem req/ack handshake and redirects on taken
// branches/jumps. Optional macro MISALIGN_TRAP_EN traps misaligned targets to TRAP_VEC.
module fetch_pc_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_valid,
  input  logic        b_out,
  input  logic        jump_en,
  input  logic [31:0] target_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  fetch_state_t state, state_n;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_addr;
  logic         kill;
  logic         taken;
  logic         req_active;
  logic         capture;
  logic [31:0]  redirect_target;

  function automatic logic [31:0] redirect_pc(input logic [31:0] tgt);
`ifdef MISALIGN_TRAP_EN
    redirect_pc = (tgt[1:0] != 2'b00) ? TRAP_VEC : tgt;
`else
    redirect_pc = tgt & 32'hFFFF_FFFC;
`endif
  endfunction

`ifndef MISALIGN_TRAP_EN
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  assign taken           = branch_valid & (b_out | jump_en);
  assign req_active      = (state == REQ) || (state == WAIT);
  assign capture         = req_active & imem_ack;
  assign redirect_target = redirect_pc(target_addr);

  assign imem_req  = req_active;
  // A killed request keeps its original address on the bus until acked.
  assign imem_addr = (state == WAIT) ? req_addr : fetch_pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = REQ;
      REQ, WAIT: begin
        if (taken)         state_n = imem_ack ? REQ : WAIT;
        else if (imem_ack) state_n = (kill || !stall) ? REQ : HOLD;
        else               state_n = WAIT;
      end
      HOLD: if (taken || !stall) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      kill        <= 1'b0;
      flush       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
`endif
    end else begin
      state <= state_n;
      flush <= taken;
`ifdef MISALIGN_TRAP_EN
      misalign_fault <= taken & (target_addr[1:0] != 2'b00);
`endif
      if (taken) begin
        kill        <= req_active & ~imem_ack;
        fetch_pc    <= redirect_target;
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
      end else if (capture && kill) begin
        // Response to a redirected-away fetch: discard and refetch from fetch_pc.
        kill        <= 1'b0;
        instr_valid <= instr_valid & stall;
      end else if (capture) begin
        instr       <= imem_rdata;
        pc          <= fetch_pc;
        instr_valid <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (req_active) begin
        instr_valid <= instr_valid & stall;
      end else if (state == HOLD && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Address latch for the outstanding request; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (state == REQ) req_addr <= fetch_pc;
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios then randomized traffic
// against a transaction-level fetch model. Honours MISALIGN_TRAP_EN if defined.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_valid, b_out, jump_en, stall;
  logic [31:0] target_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, flush;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  fetch_pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst),
    .branch_valid(branch_valid), .b_out(b_out), .jump_en(jump_en),
    .target_addr(target_addr), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .flush(flush)
`ifdef MISALIGN_TRAP_EN
    , .misalign_fault(misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder knobs
  int  lat_cfg = 0;
  bit  stray_en = 0;
  bit  force_ack = 0;
  bit  mem_busy = 0;
  int  mem_cnt = 0;
  int  mem_lat = 0;

  // Reference model: one open request, a discard flag for redirected-away fetches
  bit          m_started, m_req_open, m_hold, m_discard;
  logic [31:0] m_req_addr, m_next_pc;
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_flush;
`ifdef MISALIGN_TRAP_EN
  logic        m_fault;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] fix_target(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? TRAP_VEC : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_req_open = 0; m_hold = 0; m_discard = 0;
    m_next_pc = RESET_PC; m_req_addr = RESET_PC;
    m_pc = RESET_PC; m_instr = NOP; m_valid = 0; m_flush = 0;
`ifdef MISALIGN_TRAP_EN
    m_fault = 0;
`endif
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req_open});
    if (m_req_open) chk("imem_addr", imem_addr, m_req_addr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
`ifdef MISALIGN_TRAP_EN
    chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, m_fault});
`endif
  endtask

  // One clock: check state at negedge, drive inputs, advance model, wait to next negedge.
  task automatic cycle(input logic r, input logic bv, input logic bo, input logic je,
                       input logic [31:0] tgt, input logic st);
    logic t, a;
    logic [31:0] nt;
    check_outputs();
    rst = r; branch_valid = bv; b_out = bo; jump_en = je; target_addr = tgt; stall = st;
    if (force_ack) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1; mem_cnt = 0;
        mem_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      imem_ack = (mem_cnt == mem_lat);
      mem_cnt++;
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    end else begin
      imem_ack = stray_en && ($urandom_range(0, 7) == 0);
      imem_rdata = $urandom;
    end

    if (r) model_reset();
    else begin
      t = bv & (bo | je);
      a = imem_ack & m_req_open;
      if (t) begin
        nt = fix_target(tgt);
        m_flush = 1; m_valid = 0; m_instr = NOP; m_next_pc = nt;
`ifdef MISALIGN_TRAP_EN
        m_fault = (tgt[1:0] != 2'b00);
`endif
        if (m_req_open && !a) m_discard = 1;
        else begin
          m_discard = 0; m_hold = 0; m_req_open = 1; m_req_addr = nt;
        end
      end else begin
        m_flush = 0;
`ifdef MISALIGN_TRAP_EN
        m_fault = 0;
`endif
        if (!m_started) begin
          m_req_open = 1; m_req_addr = m_next_pc;
        end else if (m_hold) begin
          if (!st) begin
            m_hold = 0; m_valid = 0; m_req_open = 1; m_req_addr = m_next_pc;
          end
        end else if (m_req_open) begin
          if (a && m_discard) begin
            m_discard = 0; m_req_addr = m_next_pc;
          end else if (a) begin
            m_instr = imem_rdata; m_pc = m_next_pc; m_valid = 1;
            m_next_pc = m_next_pc + 32'd4;
            if (st) begin
              m_hold = 1; m_req_open = 0;
            end else m_req_addr = m_next_pc;
          end else m_valid = m_valid & st;
        end
      end
      m_started = 1;
    end
    if (r || imem_ack) mem_busy = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_mis;
    rst = 1'b1; branch_valid = 0; b_out = 0; jump_en = 0; stall = 0;
    target_addr = 0; imem_ack = 0; imem_rdata = 0;
    @(posedge clk); @(negedge clk);
    model_reset();
    cycle(1'b1, 0, 0, 0, 32'h0, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait sequential fetch
    lat_cfg = 0;
    idle(2);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", pc, 32'h0);
    idle(3);
    chk("seq_pc_c", pc, 32'hC);

    // Three-cycle ack latency: request held 4 cycles, one instruction
    lat_cfg = 3;
    idle(4);
    chk("dly_pc", pc, 32'h10);
    chk("dly_valid", {31'd0, instr_valid}, 32'd1);

    // Taken branch while waiting: flush, late ack dropped, refetch at 0x40
    idle(1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0);
    chk("br_flush", {31'd0, flush}, 32'd1);
    idle(1);
    chk("br_flush_clr", {31'd0, flush}, 32'd0);
    lat_cfg = 0;
    idle(1);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    idle(1);
    chk("br_pc", pc, 32'h40);

    // Stall for two cycles after capture
    cycle(1'b0, 0, 0, 0, 32'h0, 1'b1);
    cycle(1'b0, 0, 0, 0, 32'h0, 1'b1);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_pc", pc, 32'h44);
    cycle(1'b0, 0, 0, 0, 32'h0, 1'b0);
    idle(1);
    chk("resume_pc", pc, 32'h48);

    // Redirect and stall together: redirect wins
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
    chk("rs_addr", imem_addr, 32'h80);
    chk("rs_req", {31'd0, imem_req}, 32'd1);

    // Misaligned target
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h42, 1'b0);
`ifdef MISALIGN_TRAP_EN
    exp_mis = TRAP_VEC;
    chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
`else
    exp_mis = 32'h40;
`endif
    chk("mis_addr", imem_addr, exp_mis);

    // branch_valid without b_out/jump_en has no effect
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0);
    chk("nb_flush", {31'd0, flush}, 32'd0);
    chk("nb_addr", imem_addr, exp_mis + 32'd4);

    // Back-to-back redirects while waiting: latest target wins
    lat_cfg = 3;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0);
    idle(2);
    chk("b2b_addr", imem_addr, 32'h400);

    // Reset mid-fetch, then a stray ack while idle must be ignored
    idle(1);
    cycle(1'b1, 0, 0, 0, 32'h0, 0);
    force_ack = 1;
    idle(1);
    force_ack = 0;
    chk("rst_refetch", imem_addr, RESET_PC);
    chk("rst_nvalid", {31'd0, instr_valid}, 32'd0);

    // Randomized traffic
    lat_cfg = -1;
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      logic r, bv, bo, je, st;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 399) == 0);
      bv  = ($urandom_range(0, 5) == 0);
      bo  = $urandom_range(0, 1);
      je  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      cycle(r, bv, bo, je, tgt, st);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
